// File: rtl/funct_generator_pkg.sv
// Shared types for the function-generator sample path.
// Fixes the sample format and the reader FSM state encoding.
package funct_generator_pkg;

  localparam int unsigned DataWidthOut = 16;

  // Signed Q4.(W-4): bit 3 is the sign, bits 2..0 are integer, the rest fractional.
  typedef logic signed [3:4-DataWidthOut] sample_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/funct_generator_rate_div.sv
// Programmable sample-period divider: ticks once every div+1 running cycles.
// The period is latched on start and at every tick.
module funct_generator_rate_div #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  assign tick_o = run_i && (cnt_q == div_q);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (start_i || tick_o) begin
      cnt_d = '0;
      div_d = div_i;
    end else if (run_i) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/funct_generator_fifo_reader.sv
// Drains the generator FIFO at the programmed sample rate into a held output sample,
// flagging and counting ticks that find the FIFO empty.
module funct_generator_fifo_reader
  import funct_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_OUT = DataWidthOut,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned UFL_CNT_WIDTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic [DIV_WIDTH-1:0]            div_i,
  input  logic                            clr_i,
  input  logic                            fifo_empty_i,
  input  logic signed [3:4-DATA_WIDTH_OUT] fifo_data_i,
  output logic                            fifo_rd_o,
  output logic signed [3:4-DATA_WIDTH_OUT] data_o,
  output logic                            valid_o,
  output logic                            underflow_o,
  output logic [UFL_CNT_WIDTH-1:0]        underflow_cnt_o,
  output logic                            busy_o
);

  state_e state_q, state_d;
  logic   inflight_q;
  logic   valid_q;
  logic   ufl_q, ufl_d;
  logic [UFL_CNT_WIDTH-1:0]         ufl_cnt_q, ufl_cnt_d;
  logic signed [3:4-DATA_WIDTH_OUT] data_q;

  logic start, run, tick, rd, ufl_evt;

  // The exit cycle (en_i low) and a reset cycle never tick, so no pop can be lost.
  assign start = (state_q == StIdle) && en_i;
  assign run   = (state_q == StRun) && en_i && rst_ni;

  funct_generator_rate_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start),
    .run_i  (run),
    .div_i  (div_i),
    .tick_o (tick)
  );

  assign rd      = tick && !fifo_empty_i;
  assign ufl_evt = tick && fifo_empty_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_i) state_d = StRun;
      StRun:   if (!en_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // An underflow event takes priority over a same-cycle clear.
  always_comb begin
    ufl_d     = ufl_q;
    ufl_cnt_d = ufl_cnt_q;
    if (ufl_evt) begin
      ufl_d = 1'b1;
      if (clr_i) begin
        ufl_cnt_d = UFL_CNT_WIDTH'(1);
      end else if (ufl_cnt_q != '1) begin
        ufl_cnt_d = ufl_cnt_q + UFL_CNT_WIDTH'(1);
      end
    end else if (clr_i) begin
      ufl_d     = 1'b0;
      ufl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ufl_q      <= 1'b0;
      ufl_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd;
      valid_q    <= inflight_q;
      if (inflight_q) data_q <= fifo_data_i;
      ufl_q      <= ufl_d;
      ufl_cnt_q  <= ufl_cnt_d;
    end
  end

  assign fifo_rd_o       = rd;
  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign underflow_o     = ufl_q;
  assign underflow_cnt_o = ufl_cnt_q;
  assign busy_o          = (state_q == StRun) || inflight_q;

endmodule
